// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60Hz timing constants, 12-bit colour constants
//               and playfield geometry for the VGA timing generator and the
//               downstream block/paddle/ball renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // Raster timing (pixel units / line units)
  localparam int VGA_CLK_DIV     = 4;    // 100 MHz / 4 = 25 MHz pixel rate
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 783;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 514;
  localparam int VGA_TICK_DIV    = 1;
  localparam int VGA_CNT_W       = 10;

  // 12-bit RGB (4:4:4) colours used by the renderers
  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOR_RED    = 12'hF00;
  localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE   = 12'h00F;
  localparam logic [11:0] COLOR_YELLOW = 12'hFF0;

  // Playfield edges coincide with the visible window
  localparam int WALL_LEFT  = VGA_H_ACT_START;
  localparam int WALL_RIGHT = VGA_H_ACT_END;
  localparam int CEILING    = VGA_V_ACT_START;
  localparam int FLOOR      = VGA_V_ACT_END;

  // Inclusive range test on a raster coordinate
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] pos,
                                     input logic [VGA_CNT_W-1:0] lo,
                                     input logic [VGA_CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_clk_en_div.sv
// ============================================================================
// Module      : vga_clk_en_div
// Description : Generic divide-by-DIV enable generator. Counts qualifying
//               enable cycles 0..DIV-1 and emits a registered one-clk pulse
//               in the cycle after the count wraps.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               en   - count qualifier (tie high for a free-running divider)
//               tick - registered one-clk pulse every DIV enabled cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_clk_en_div
  import vga_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  generate
    if (DIV <= 1) begin : g_passthru
      // Divide-by-one: every enabled cycle produces a pulse
      logic tick_q, tick_d;

      always_comb begin
        tick_d = en;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= tick_d;
      end

      assign tick = tick_q;
    end else begin : g_count
      localparam int             CW   = $clog2(DIV);
      localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          tick_q, tick_d;

      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en) begin
          // >= rather than == so a corrupted count still wraps
          if (cnt_q >= LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          tick_q <= tick_d;
        end
      end

      assign tick = tick_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60Hz VGA raster timing from the 100 MHz board clock.
//               Produces pixel enable, h/v counters, active-low syncs, the
//               visible-window flag and line/frame/game update ticks.
// Ports       : clk        - 100 MHz clock
//               rst        - asynchronous active-high reset
//               pix_en     - one-clk pulse per pixel period
//               hCount     - horizontal position 0..H_TOTAL-1
//               vCount     - vertical position 0..V_TOTAL-1
//               hSync      - horizontal sync, active-low
//               vSync      - vertical sync, active-low
//               bright     - high inside the visible window
//               line_tick  - one-clk pulse when hCount wraps
//               frame_tick - one-clk pulse when the frame wraps
//               game_tick  - one-clk pulse every TICK_DIV frames
//               pix_x/pix_y- visible-area coordinates (only with
//                            VGA_TIMING_PIXEL_XY_EN defined)
// Options     : `define VGA_TIMING_PIXEL_XY_EN adds pix_x / pix_y outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END,
  parameter int TICK_DIV    = VGA_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       game_tick
`ifdef VGA_TIMING_PIXEL_XY_EN
  ,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
`endif
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);
  localparam logic [9:0] H_AS   = 10'(H_ACT_START);
  localparam logic [9:0] H_AE   = 10'(H_ACT_END);
  localparam logic [9:0] V_AS   = 10'(V_ACT_START);
  localparam logic [9:0] V_AE   = 10'(V_ACT_END);

  logic pix_en_w;
  logic h_wrap_w;
  logic frame_wrap_w;
  logic game_tick_w;

  logic [9:0] hCount_q, hCount_d;
  logic [9:0] vCount_q, vCount_d;
  logic       hSync_q, hSync_d;
  logic       vSync_q, vSync_d;
  logic       bright_q, bright_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;

  // Pixel-rate enable: free-running divide by CLK_DIV
  vga_clk_en_div #(
    .DIV (CLK_DIV)
  ) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (pix_en_w)
  );

  always_comb begin
    h_wrap_w     = pix_en_w && (hCount_q >= H_LAST);
    frame_wrap_w = h_wrap_w && (vCount_q >= V_LAST);

    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (pix_en_w) begin
      if (h_wrap_w) begin
        hCount_d = '0;
        vCount_d = (vCount_q >= V_LAST) ? '0 : vCount_q + 10'd1;
      end else begin
        hCount_d = hCount_q + 10'd1;
        // An out-of-range line number is pulled back on the next pixel
        if (vCount_q > V_LAST) vCount_d = '0;
      end
    end

    // Decoding the next-state position keeps syncs/bright aligned with
    // the counters they describe
    hSync_d      = (hCount_d >= H_SW);
    vSync_d      = (vCount_d >= V_SW);
    bright_d     = in_window(hCount_d, H_AS, H_AE) && in_window(vCount_d, V_AS, V_AE);
    line_tick_d  = h_wrap_w;
    frame_tick_d = frame_wrap_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount_q     <= '0;
      vCount_q     <= '0;
      hSync_q      <= 1'b0;
      vSync_q      <= 1'b0;
      bright_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      bright_q     <= bright_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Frame divider is fed the combinational wrap so its registered pulse
  // lands in the same cycle as frame_tick
  vga_clk_en_div #(
    .DIV (TICK_DIV)
  ) u_game_div (
    .clk  (clk),
    .rst  (rst),
    .en   (frame_wrap_w),
    .tick (game_tick_w)
  );

`ifdef VGA_TIMING_PIXEL_XY_EN
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;

  always_comb begin
    pix_x_d = bright_d ? (hCount_d - H_AS) : '0;
    pix_y_d = bright_d ? (vCount_d - V_AS) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
    end
  end

  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
`endif

  assign pix_en     = pix_en_w;
  assign hCount     = hCount_q;
  assign vCount     = vCount_q;
  assign hSync      = hSync_q;
  assign vSync      = vSync_q;
  assign bright     = bright_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;
  assign game_tick  = game_tick_w;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. A default-parameter
//               instance covers reset, pixel enable and horizontal timing;
//               a shrunken-raster instance (TICK_DIV=3) covers whole frames.
//               Expected values come from a closed-form model of position
//               versus clk edges since reset release.
// Options     : VGA_TIMING_PIXEL_XY_EN enables pix_x / pix_y checks
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int F_D = 4,  F_H = 800, F_HS = 96, F_HAS = 144, F_HAE = 783;
  localparam int F_V = 525, F_VS = 2, F_VAS = 35, F_VAE = 514, F_T = 1;
  localparam int S_D = 2,  S_H = 40,  S_HS = 5,  S_HAS = 8,   S_HAE = 35;
  localparam int S_V = 20, S_VS = 2,  S_VAS = 4, S_VAE = 15,  S_T = 3;

  typedef struct packed {
    logic       pe;
    logic       lt;
    logic       ft;
    logic       gt;
    logic       hs;
    logic       vs;
    logic       br;
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] px;
    logic [9:0] py;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       f_pe, f_hs, f_vs, f_br, f_lt, f_ft, f_gt;
  logic [9:0] f_h, f_v;
  logic       s_pe, s_hs, s_vs, s_br, s_lt, s_ft, s_gt;
  logic [9:0] s_h, s_v;
`ifdef VGA_TIMING_PIXEL_XY_EN
  logic [9:0] f_px, f_py, s_px, s_py;
`endif

  int   total = 0;
  int   bad   = 0;
  int   e     = 0;   // clk edges since reset release
  obs_t q_full[$];
  obs_t q_small[$];

  always #5 clk = ~clk;

  vga_timing_gen u_full (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (f_pe),
    .hCount     (f_h),
    .vCount     (f_v),
    .hSync      (f_hs),
    .vSync      (f_vs),
    .bright     (f_br),
    .line_tick  (f_lt),
    .frame_tick (f_ft),
    .game_tick  (f_gt)
`ifdef VGA_TIMING_PIXEL_XY_EN
    ,
    .pix_x      (f_px),
    .pix_y      (f_py)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV (S_D), .H_TOTAL (S_H), .H_SYNC (S_HS), .H_ACT_START (S_HAS),
    .H_ACT_END (S_HAE), .V_TOTAL (S_V), .V_SYNC (S_VS),
    .V_ACT_START (S_VAS), .V_ACT_END (S_VAE), .TICK_DIV (S_T)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (s_pe),
    .hCount     (s_h),
    .vCount     (s_v),
    .hSync      (s_hs),
    .vSync      (s_vs),
    .bright     (s_br),
    .line_tick  (s_lt),
    .frame_tick (s_ft),
    .game_tick  (s_gt)
`ifdef VGA_TIMING_PIXEL_XY_EN
    ,
    .pix_x      (s_px),
    .pix_y      (s_py)
`endif
  );

  // Position after e edges: first pix_en registers at edge d, counters move
  // on the edge after each pix_en, so edge e shows pixel index (e-1)/d.
  function automatic obs_t model(input int ev, input int d, input int ht,
                                 input int hsw, input int has, input int hae,
                                 input int vt, input int vsw, input int vas,
                                 input int vae, input int t);
    obs_t r;
    int   n, h, v;
    bit   first;
    r     = '0;
    n     = (ev == 0) ? 0 : (ev - 1) / d;
    h     = n % ht;
    v     = (n / ht) % vt;
    first = (ev > 1) && (((ev - 1) % d) == 0);
    r.pe  = (ev >= d) && ((ev % d) == 0);
    r.h   = 10'(h);
    r.v   = 10'(v);
    r.hs  = (h >= hsw);
    r.vs  = (v >= vsw);
    r.br  = (h >= has) && (h <= hae) && (v >= vas) && (v <= vae);
    r.lt  = first && (h == 0);
    r.ft  = first && (h == 0) && (v == 0);
    r.gt  = r.ft && (((n / (ht * vt)) % t) == 0);
`ifdef VGA_TIMING_PIXEL_XY_EN
    if (r.br) begin
      r.px = 10'(h - has);
      r.py = 10'(v - vas);
    end
`endif
    return r;
  endfunction

  function automatic obs_t full_obs();
    obs_t r;
    r = '0;
    r.pe = f_pe; r.lt = f_lt; r.ft = f_ft; r.gt = f_gt;
    r.hs = f_hs; r.vs = f_vs; r.br = f_br; r.h = f_h; r.v = f_v;
`ifdef VGA_TIMING_PIXEL_XY_EN
    r.px = f_px; r.py = f_py;
`endif
    return r;
  endfunction

  function automatic obs_t small_obs();
    obs_t r;
    r = '0;
    r.pe = s_pe; r.lt = s_lt; r.ft = s_ft; r.gt = s_gt;
    r.hs = s_hs; r.vs = s_vs; r.br = s_br; r.h = s_h; r.v = s_v;
`ifdef VGA_TIMING_PIXEL_XY_EN
    r.px = s_px; r.py = s_py;
`endif
    return r;
  endfunction

  // Advance one clk: expectation queued at the edge, sampling at negedge
  task automatic step(input bit full);
    @(posedge clk);
    e++;
    if (full) q_full.push_back(model(e, F_D, F_H, F_HS, F_HAS, F_HAE, F_V, F_VS, F_VAS, F_VAE, F_T));
    else      q_small.push_back(model(e, S_D, S_H, S_HS, S_HAS, S_HAE, S_V, S_VS, S_VAS, S_VAE, S_T));
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (full_obs() !== zero) begin bad++; $display("FAIL reset_full got=%h exp=%h", full_obs(), zero); end
    total++;
    if (small_obs() !== zero) begin bad++; $display("FAIL reset_small got=%h exp=%h", small_obs(), zero); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (full_obs() !== zero) begin bad++; $display("FAIL reset_hold got=%h exp=%h", full_obs(), zero); end
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic test_pix_en();
    obs_t x, a;
    int   first = -1;
    int   last  = -1;
    for (int k = 0; k < 40; k++) begin
      step(1'b1);
      x = q_full.pop_front();
      a = full_obs();
      total++;
      if (a !== x) begin bad++; $display("FAIL pix_en_seq e=%0d got=%h exp=%h", e, a, x); end
      if (a.pe) begin
        if (first < 0) begin
          first = e;
        end else begin
          total++;
          if ((e - last) != F_D) begin bad++; $display("FAIL pix_en_period e=%0d got=%0d exp=%0d", e, e - last, F_D); end
        end
        last = e;
      end
    end
    total++;
    if (first != F_D) begin bad++; $display("FAIL pix_en_first got=%0d exp=%0d", first, F_D); end
  endtask

  task automatic test_horizontal();
    obs_t x, a;
    int   lt_prev = -1;
    int   hs_low  = 0;
    int   lines   = 0;
    while (e < 6600) begin
      step(1'b1);
      x = q_full.pop_front();
      a = full_obs();
      total++;
      if (a !== x) begin bad++; $display("FAIL horiz_seq e=%0d h=%0d v=%0d got=%h exp=%h", e, a.h, a.v, a, x); end
      if (a.lt) begin
        if (lt_prev >= 0) begin
          total++;
          if ((e - lt_prev) != F_H * F_D) begin bad++; $display("FAIL line_period got=%0d exp=%0d", e - lt_prev, F_H * F_D); end
          total++;
          if (hs_low != F_HS * F_D) begin bad++; $display("FAIL hsync_low got=%0d exp=%0d", hs_low, F_HS * F_D); end
        end
        lt_prev = e;
        hs_low  = 0;
        lines++;
      end
      if (!a.hs) hs_low++;
    end
    total++;
    if (lines != 2) begin bad++; $display("FAIL line_count got=%0d exp=2", lines); end
  endtask

  task automatic test_mid_reset();
    obs_t zero;
    int   guard = 0;
    zero = '0;
    while ((f_h < 10'd100) && (guard < 2000)) begin
      step(1'b1);
      void'(q_full.pop_front());
      guard++;
    end
    total++;
    if (guard >= 2000) begin bad++; $display("FAIL mid_reset_wait got=timeout exp=hCount>=100"); end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (full_obs() !== zero) begin bad++; $display("FAIL mid_reset_full got=%h exp=%h", full_obs(), zero); end
    total++;
    if (small_obs() !== zero) begin bad++; $display("FAIL mid_reset_small got=%h exp=%h", small_obs(), zero); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
    q_full.delete();
    q_small.delete();
  endtask

  task automatic test_frame();
    obs_t x, a;
    int   ft_prev = -1, ft_n = 0, gt_n = 0, br_cnt = 0, br_bad = 0, early = 0;
    bit   seen_br = 1'b0, prev_br = 1'b0;
    while (e < 3 * S_H * S_V * S_D + 40) begin
      step(1'b0);
      x = q_small.pop_front();
      a = small_obs();
      total++;
      if (a !== x) begin bad++; $display("FAIL frame_seq e=%0d h=%0d v=%0d got=%h exp=%h", e, a.h, a.v, a, x); end
      if (a.ft) begin
        if (ft_prev >= 0) begin
          total++;
          if ((e - ft_prev) != S_H * S_V * S_D) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", e - ft_prev, S_H * S_V * S_D); end
          total++;
          if (br_cnt != (S_HAE - S_HAS + 1) * (S_VAE - S_VAS + 1) * S_D) begin
            bad++; $display("FAIL bright_total got=%0d exp=%0d", br_cnt, (S_HAE - S_HAS + 1) * (S_VAE - S_VAS + 1) * S_D);
          end
        end
        ft_prev = e;
        br_cnt  = 0;
        ft_n++;
      end
      if (a.gt) begin
        gt_n++;
        total++;
        if ((ft_n != 3) || !a.ft) begin bad++; $display("FAIL game_tick_phase got=frame%0d ft=%0b exp=frame3 ft=1", ft_n, a.ft); end
      end
      if (a.br) br_cnt++;
      if (a.br && (a.v == 10'(S_VAE + 1))) br_bad++;
      if ((e <= S_H * S_D) && (a.lt || a.ft || a.gt)) early++;
      if (a.br && !seen_br) begin
        seen_br = 1'b1;
        total++;
        if ((a.h != 10'(S_HAS)) || (a.v != 10'(S_VAS))) begin bad++; $display("FAIL bright_rise got=(%0d,%0d) exp=(%0d,%0d)", a.h, a.v, S_HAS, S_VAS); end
      end
      if (prev_br && !a.br) begin
        total++;
        if (a.h != 10'(S_HAE + 1)) begin bad++; $display("FAIL bright_fall got=%0d exp=%0d", a.h, S_HAE + 1); end
      end
      prev_br = a.br;
`ifdef VGA_TIMING_PIXEL_XY_EN
      if ((a.h == 10'(S_HAS)) && (a.v == 10'(S_VAS))) begin
        total++;
        if ((a.px != 10'd0) || (a.py != 10'd0)) begin bad++; $display("FAIL pix_xy_origin got=(%0d,%0d) exp=(0,0)", a.px, a.py); end
      end
      if ((a.h == 10'(S_HAE)) && (a.v == 10'(S_VAE))) begin
        total++;
        if ((a.px != 10'(S_HAE - S_HAS)) || (a.py != 10'(S_VAE - S_VAS))) begin
          bad++; $display("FAIL pix_xy_corner got=(%0d,%0d) exp=(%0d,%0d)", a.px, a.py, S_HAE - S_HAS, S_VAE - S_VAS);
        end
      end
      if ((a.h == 10'(S_HAS - 2)) && (a.v == 10'(S_VAS + 3))) begin
        total++;
        if ((a.px != 10'd0) || (a.py != 10'd0)) begin bad++; $display("FAIL pix_xy_blank got=(%0d,%0d) exp=(0,0)", a.px, a.py); end
      end
`endif
    end
    total++;
    if (ft_n != 3) begin bad++; $display("FAIL frame_count got=%0d exp=3", ft_n); end
    total++;
    if (gt_n != 1) begin bad++; $display("FAIL game_tick_count got=%0d exp=1", gt_n); end
    total++;
    if (br_bad != 0) begin bad++; $display("FAIL bright_below_window got=%0d exp=0", br_bad); end
    total++;
    if (early != 0) begin bad++; $display("FAIL early_tick got=%0d exp=0", early); end
  endtask

  initial begin
    test_reset();
    test_pix_en();
    test_horizontal();
    test_mid_reset();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
